// File: rtl/csr_arbiter_pkg.sv
// Shared definitions for the CSR arbiter: FSM state encoding, requester
// indices and the default lock timeout.
package csr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int unsigned LOCK_TIMEOUT_DEF = 255;
  localparam int unsigned IDLE_W           = 8;

endpackage

// File: rtl/csr_arbiter.sv
// Two-requester arbiter (SPI slave m0, secondary bridge m1) in front of the
// shared cdbus CSR port, with lock ownership, idle-timeout release and read return.
module csr_arbiter
  import csr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] csr_address,
  output logic              csr_read,
  output logic              csr_write,
  output logic [DATA_W-1:0] csr_writedata,
  input  logic [DATA_W-1:0] csr_readdata,

  output logic [1:0]        lock_owner
);

  localparam logic [IDLE_W-1:0] TIMEOUT_MAX  = IDLE_W'(LOCK_TIMEOUT);
  localparam logic [IDLE_W-1:0] TIMEOUT_LAST = TIMEOUT_MAX - 1'b1;

  arb_state_t        state_q, state_d;
  logic              rr_last_q;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              rd_pend_q;
  logic              rd_owner_q;

  logic req0, req1;
  logic gnt0, gnt1;
  logic own_req, own_lock;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    state_d  = state_q;
    idle_d   = idle_q;
    unique case (state_q)
      ST_FREE: begin
        idle_d = '0;
        if (req0 && (!req1 || rr_last_q == REQ_M1)) gnt0 = 1'b1;
        else if (req1)                              gnt1 = 1'b1;
        if (gnt0 && m0_lock)      state_d = ST_OWN0;
        else if (gnt1 && m1_lock) state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        own_req  = (state_q == ST_OWN0) ? req0 : req1;
        own_lock = (state_q == ST_OWN0) ? m0_lock : m1_lock;
        gnt0     = (state_q == ST_OWN0) && req0;
        gnt1     = (state_q == ST_OWN1) && req1;
        // Dropping the lock releases even while the final access is granted.
        if (!own_lock) begin
          state_d = ST_FREE;
          idle_d  = '0;
        end else if (own_req) begin
          idle_d = '0;
        end else if (idle_q >= TIMEOUT_LAST) begin
          idle_d  = TIMEOUT_MAX;
          state_d = ST_FREE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = ST_FREE;
    endcase
    if (!reset_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Shared port mirrors the granted requester; read wins over a simultaneous write.
  always_comb begin
    csr_address   = '0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = '0;
    if (gnt0) begin
      csr_address   = m0_address;
      csr_read      = m0_read;
      csr_write     = m0_write & ~m0_read;
      csr_writedata = m0_writedata;
    end else if (gnt1) begin
      csr_address   = m1_address;
      csr_read      = m1_read;
      csr_write     = m1_write & ~m1_read;
      csr_writedata = m1_writedata;
    end
  end

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_FREE;
      rr_last_q  <= REQ_M1;
      idle_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_M0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      if (gnt0)      rr_last_q <= REQ_M0;
      else if (gnt1) rr_last_q <= REQ_M1;
      rd_pend_q  <= csr_read;
      rd_owner_q <= gnt1 ? REQ_M1 : REQ_M0;
    end
  end

  assign m0_readdatavalid = rd_pend_q && (rd_owner_q == REQ_M0);
  assign m1_readdatavalid = rd_pend_q && (rd_owner_q == REQ_M1);
  assign m0_readdata      = m0_readdatavalid ? csr_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? csr_readdata : '0;

  assign lock_owner = state_q;

endmodule
